// File: rtl/signal_pkg.sv
// Shared encodings for the signal lamp driver: FSM state codes, lamp patterns
// and the state-to-lamp decode used by the output registers.
package signal_pkg;

    localparam logic [2:0] ST_ALL_RED = 3'd0;
    localparam logic [2:0] ST_A_GREEN = 3'd1;
    localparam logic [2:0] ST_A_AMBER = 3'd2;
    localparam logic [2:0] ST_CLR_AB  = 3'd3;
    localparam logic [2:0] ST_B_GREEN = 3'd4;
    localparam logic [2:0] ST_B_AMBER = 3'd5;
    localparam logic [2:0] ST_CLR_BA  = 3'd6;
    localparam logic [2:0] ST_FAULT   = 3'd7;

    typedef struct packed {
        logic red;
        logic amber;
        logic green;
    } lamp_t;

    typedef struct packed {
        lamp_t a;
        lamp_t b;
    } lamp_pair_t;

    localparam lamp_t LAMP_OFF   = 3'b000;
    localparam lamp_t LAMP_RED   = 3'b100;
    localparam lamp_t LAMP_AMBER = 3'b010;
    localparam lamp_t LAMP_GREEN = 3'b001;

    // Every non-fault state shows red on an approach unless it owns green/amber.
    function automatic lamp_pair_t state_lamps(input logic [2:0] state, input logic blink);
        lamp_pair_t lamps;
        lamps.a = LAMP_RED;
        lamps.b = LAMP_RED;
        case (state)
            ST_A_GREEN: lamps.a = LAMP_GREEN;
            ST_A_AMBER: lamps.a = LAMP_AMBER;
            ST_B_GREEN: lamps.b = LAMP_GREEN;
            ST_B_AMBER: lamps.b = LAMP_AMBER;
            ST_FAULT: begin
                lamps.a = blink ? LAMP_RED : LAMP_OFF;
                lamps.b = blink ? LAMP_RED : LAMP_OFF;
            end
            default: ;
        endcase
        return lamps;
    endfunction

endpackage

// File: rtl/phase_cnt.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module phase_cnt #(
    parameter int unsigned NBITS = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [NBITS-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [NBITS-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && !zero)
            count <= count - NBITS'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/signal_lamp_drv.sv
// Two-approach traffic lamp driver: green/amber/clearance sequencing with a
// latching blink-red fault mode for contradictory controller requests.
module signal_lamp_drv
    import signal_pkg::*;
#(
    parameter int unsigned NBITS     = 32,
    parameter logic [31:0] AMBER_CYC = 32'h20,
    parameter logic [31:0] CLEAR_CYC = 32'h10,
    parameter logic [31:0] BLINK_CYC = 32'h08
) (
    input  logic clk,
    input  logic reset_n,
    input  logic Ago,
    input  logic Astop,
    input  logic Bgo,
    input  logic Bstop,
    output logic a_red,
    output logic a_amber,
    output logic a_green,
    output logic b_red,
    output logic b_amber,
    output logic b_green,
    output logic fault
);

    localparam logic [NBITS-1:0] AMBER_LD = NBITS'(AMBER_CYC - 32'd1);
    localparam logic [NBITS-1:0] CLEAR_LD = NBITS'(CLEAR_CYC - 32'd1);
    localparam logic [NBITS-1:0] BLINK_LD = NBITS'(BLINK_CYC - 32'd1);

    logic             ago_q, astop_q, bgo_q, bstop_q;
    logic [2:0]       state, next_state;
    logic             blink, blink_next;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [NBITS-1:0] cnt_load_val;
    logic             fault_cond;
    lamp_pair_t       lamps_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ago_q   <= 1'b0;
            astop_q <= 1'b0;
            bgo_q   <= 1'b0;
            bstop_q <= 1'b0;
        end else begin
            ago_q   <= Ago;
            astop_q <= Astop;
            bgo_q   <= Bgo;
            bstop_q <= Bstop;
        end
    end

    phase_cnt #(.NBITS(NBITS)) u_phase_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign fault_cond = (ago_q & bgo_q) | (ago_q & astop_q) | (bgo_q & bstop_q);

    // Fault wins over everything; otherwise timed states count down the shared
    // counter, which the fault state then reuses as the blink half-period timer.
    always_comb begin
        next_state   = state;
        blink_next   = blink;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        if (state != ST_FAULT && fault_cond) begin
            next_state   = ST_FAULT;
            blink_next   = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = BLINK_LD;
        end else begin
            case (state)
                ST_ALL_RED: begin
                    if (ago_q && !astop_q)
                        next_state = ST_A_GREEN;
                    else if (bgo_q && !bstop_q)
                        next_state = ST_B_GREEN;
                end
                ST_A_GREEN: begin
                    if (astop_q) begin
                        next_state   = ST_A_AMBER;
                        cnt_load     = 1'b1;
                        cnt_load_val = AMBER_LD;
                    end
                end
                ST_A_AMBER: begin
                    if (cnt_zero) begin
                        next_state   = ST_CLR_AB;
                        cnt_load     = 1'b1;
                        cnt_load_val = CLEAR_LD;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_CLR_AB: begin
                    if (cnt_zero)
                        next_state = (bgo_q && !bstop_q) ? ST_B_GREEN : ST_ALL_RED;
                    else
                        cnt_dec = 1'b1;
                end
                ST_B_GREEN: begin
                    if (bstop_q) begin
                        next_state   = ST_B_AMBER;
                        cnt_load     = 1'b1;
                        cnt_load_val = AMBER_LD;
                    end
                end
                ST_B_AMBER: begin
                    if (cnt_zero) begin
                        next_state   = ST_CLR_BA;
                        cnt_load     = 1'b1;
                        cnt_load_val = CLEAR_LD;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_CLR_BA: begin
                    if (cnt_zero)
                        next_state = (ago_q && !astop_q) ? ST_A_GREEN : ST_ALL_RED;
                    else
                        cnt_dec = 1'b1;
                end
                ST_FAULT: begin
                    if (cnt_zero) begin
                        blink_next   = ~blink;
                        cnt_load     = 1'b1;
                        cnt_load_val = BLINK_LD;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            endcase
        end
    end

    assign lamps_next = state_lamps(next_state, blink_next);

    // Lamps are registered from the next state so they move on the same edge as the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_ALL_RED;
            blink   <= 1'b1;
            a_red   <= 1'b1;
            a_amber <= 1'b0;
            a_green <= 1'b0;
            b_red   <= 1'b1;
            b_amber <= 1'b0;
            b_green <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state   <= next_state;
            blink   <= blink_next;
            a_red   <= lamps_next.a.red;
            a_amber <= lamps_next.a.amber;
            a_green <= lamps_next.a.green;
            b_red   <= lamps_next.b.red;
            b_amber <= lamps_next.b.amber;
            b_green <= lamps_next.b.green;
            fault   <= (next_state == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_signal_lamp_drv.sv
// Bench for signal_lamp_drv: directed scenarios with literal lamp patterns plus
// a phase/elapsed-time model compared against the outputs on every falling edge.
module tb_signal_lamp_drv;

    localparam int AMBER = 4;
    localparam int CLEAR = 2;
    localparam int BLINK = 3;

    // {fault, a_red, a_amber, a_green, b_red, b_amber, b_green}
    localparam logic [6:0] RED  = 7'b0100100;
    localparam logic [6:0] AGRN = 7'b0001100;
    localparam logic [6:0] AAMB = 7'b0010100;
    localparam logic [6:0] BGRN = 7'b0100001;
    localparam logic [6:0] BAMB = 7'b0100010;
    localparam logic [6:0] FON  = 7'b1100100;
    localparam logic [6:0] FOFF = 7'b1000000;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic ago = 1'b0, astop = 1'b0, bgo = 1'b0, bstop = 1'b0;
    logic a_red, a_amber, a_green, b_red, b_amber, b_green, fault;
    logic [6:0] dut_vec;
    logic check_en = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    typedef enum int {M_RED, M_GRN_A, M_AMB_A, M_CLR_A, M_GRN_B, M_AMB_B, M_CLR_B, M_FLT} mphase_t;
    mphase_t m_phase = M_RED;
    int m_age = 0;
    logic m_ago = 1'b0, m_astop = 1'b0, m_bgo = 1'b0, m_bstop = 1'b0;

    signal_lamp_drv #(
        .NBITS(8), .AMBER_CYC(32'd4), .CLEAR_CYC(32'd2), .BLINK_CYC(32'd3)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .Ago(ago), .Astop(astop), .Bgo(bgo), .Bstop(bstop),
        .a_red(a_red), .a_amber(a_amber), .a_green(a_green),
        .b_red(b_red), .b_amber(b_amber), .b_green(b_green),
        .fault(fault)
    );

    assign dut_vec = {fault, a_red, a_amber, a_green, b_red, b_amber, b_green};

    always #5 clk = ~clk;

    function automatic logic [6:0] model_vec();
        case (m_phase)
            M_GRN_A: return AGRN;
            M_AMB_A: return AAMB;
            M_GRN_B: return BGRN;
            M_AMB_B: return BAMB;
            M_FLT:   return ((m_age / BLINK) % 2 == 0) ? FON : FOFF;
            default: return RED;
        endcase
    endfunction

    // Model: phase plus cycles spent in it, advanced from the inputs seen one edge earlier.
    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_phase = M_RED;
                m_age   = 0;
                m_ago = 1'b0; m_astop = 1'b0; m_bgo = 1'b0; m_bstop = 1'b0;
            end else begin
                mphase_t nxt;
                nxt = m_phase;
                if (m_phase != M_FLT && ((m_ago && m_bgo) || (m_ago && m_astop) || (m_bgo && m_bstop)))
                    nxt = M_FLT;
                else begin
                    case (m_phase)
                        M_RED:   nxt = (m_ago && !m_astop) ? M_GRN_A : ((m_bgo && !m_bstop) ? M_GRN_B : M_RED);
                        M_GRN_A: if (m_astop) nxt = M_AMB_A;
                        M_AMB_A: if (m_age + 1 == AMBER) nxt = M_CLR_A;
                        M_CLR_A: if (m_age + 1 == CLEAR) nxt = (m_bgo && !m_bstop) ? M_GRN_B : M_RED;
                        M_GRN_B: if (m_bstop) nxt = M_AMB_B;
                        M_AMB_B: if (m_age + 1 == AMBER) nxt = M_CLR_B;
                        M_CLR_B: if (m_age + 1 == CLEAR) nxt = (m_ago && !m_astop) ? M_GRN_A : M_RED;
                        default: ;
                    endcase
                end
                m_age   = (nxt != m_phase) ? 0 : m_age + 1;
                m_phase = nxt;
                m_ago = ago; m_astop = astop; m_bgo = bgo; m_bstop = bstop;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [6:0] got, input logic [6:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, got, want);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (check_en)
                checkOutput("cycle_model", dut_vec, model_vec());
        end
    end

    task automatic applyStimulus(input logic a_g, input logic a_s, input logic b_g, input logic b_s);
        @(negedge clk);
        ago = a_g; astop = a_s; bgo = b_g; bstop = b_s;
    endtask

    task automatic expect_run(input string name, input logic [6:0] want, input int n);
        repeat (n) begin
            @(negedge clk);
            checkOutput(name, dut_vec, want);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 reset_n = 1'b0;
        #1 check_en = 1'b1;
        expect_run("reset_state", RED, 2);
        @(negedge clk) reset_n = 1'b1;

        // A go with B stopped: green appears on the second edge
        applyStimulus(1, 0, 0, 1);
        expect_run("a_go_latency", RED, 1);
        expect_run("a_green", AGRN, 3);

        // A stop with B waiting
        applyStimulus(0, 1, 1, 0);
        expect_run("a_green_pre_amber", AGRN, 1);
        expect_run("amber_a", AAMB, 4);
        expect_run("clear_ab", RED, 2);
        expect_run("b_green", BGRN, 3);

        // B stop with A waiting, back to A green
        applyStimulus(1, 0, 0, 1);
        expect_run("b_green_pre_amber", BGRN, 1);
        expect_run("amber_b", BAMB, 4);
        expect_run("clear_ba", RED, 2);
        expect_run("a_green_again", AGRN, 2);

        // A stop with nobody waiting: all-red until B asks
        applyStimulus(0, 1, 0, 0);
        expect_run("a_green_pre_amber2", AGRN, 1);
        expect_run("amber_a2", AAMB, 4);
        expect_run("clear_ab2", RED, 2);
        expect_run("all_red_hold", RED, 5);
        applyStimulus(0, 0, 1, 0);
        expect_run("b_go_latency", RED, 1);
        expect_run("b_green_late", BGRN, 2);

        // Bgo pulse during A amber must not shorten amber or clearance
        applyStimulus(1, 0, 0, 1);
        expect_run("b_green_pre_amber2", BGRN, 1);
        expect_run("amber_b2", BAMB, 4);
        expect_run("clear_ba2", RED, 2);
        expect_run("a_green_3", AGRN, 2);
        applyStimulus(0, 1, 0, 0);
        expect_run("a_green_pre_pulse", AGRN, 1);
        expect_run("amber_pulse", AAMB, 1);
        bgo = 1'b1;
        expect_run("amber_pulse", AAMB, 1);
        bgo = 1'b0;
        expect_run("amber_pulse", AAMB, 2);
        expect_run("clear_pulse", RED, 2);
        expect_run("all_red_after_pulse", RED, 3);

        // Asynchronous reset in the middle of amber
        applyStimulus(1, 0, 0, 0);
        expect_run("a_go_latency2", RED, 1);
        expect_run("a_green_4", AGRN, 1);
        applyStimulus(0, 1, 0, 0);
        expect_run("a_green_pre_reset", AGRN, 1);
        expect_run("amber_pre_reset", AAMB, 2);
        #2 reset_n = 1'b0;
        #1 checkOutput("async_reset_amber", dut_vec, RED);
        ago = 1'b0; astop = 1'b0; bgo = 1'b0; bstop = 1'b0;
        expect_run("reset_hold", RED, 2);
        @(negedge clk) reset_n = 1'b1;
        expect_run("after_release", RED, 2);

        // Conflicting go requests: blinking red fault, latched until reset
        applyStimulus(1, 0, 1, 0);
        expect_run("fault_latency", RED, 1);
        expect_run("fault_on", FON, 3);
        expect_run("fault_off", FOFF, 3);
        expect_run("fault_on2", FON, 3);
        applyStimulus(0, 0, 0, 0);
        expect_run("fault_hold_off", FOFF, 2);
        expect_run("fault_hold_on", FON, 1);
        #2 reset_n = 1'b0;
        #1 checkOutput("async_reset_fault", dut_vec, RED);
        @(negedge clk) reset_n = 1'b1;
        expect_run("final_idle", RED, 2);

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/signal_lamp_drv.md
SIGNAL_LAMP_DRV -- requirements
Module: signal_lamp_drv

Interface
REQ-001 The block SHALL have parameter NBITS, default 32, giving the width of the phase counter.
REQ-002 The block SHALL have parameter AMBER_CYC, default 32'h20, giving the amber duration in clk cycles (legal range 1..2^NBITS-1).
REQ-003 The block SHALL have parameter CLEAR_CYC, default 32'h10, giving the all-red clearance duration in clk cycles (legal range 1..2^NBITS-1).
REQ-004 The block SHALL have parameter BLINK_CYC, default 32'h08, giving the fault blink half-period in clk cycles (legal range 1..2^NBITS-1).
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port Ago, input, 1 bit: approach A go request from the upstream signal controller.
REQ-008 Port Astop, input, 1 bit: approach A stop request from the upstream signal controller.
REQ-009 Port Bgo, input, 1 bit: approach B go request from the upstream signal controller.
REQ-010 Port Bstop, input, 1 bit: approach B stop request from the upstream signal controller.
REQ-011 Ports a_red, a_amber, a_green, b_red, b_amber, b_green, each output, 1 bit, registered: the lamp drives.
REQ-012 Port fault, output, 1 bit, registered: set when an illegal input combination has been detected.

Function
REQ-013 Inputs SHALL be registered once before use; lamp outputs SHALL change exactly 2 clk edges after an input change that causes a transition.
REQ-014 The FSM SHALL have the states ALL_RED, A_GREEN, A_AMBER, CLR_AB, B_GREEN, B_AMBER, CLR_BA and FAULT.
REQ-015 In ALL_RED, registered Ago=1 with Astop=0 SHALL go to A_GREEN; otherwise registered Bgo=1 with Bstop=0 SHALL go to B_GREEN; otherwise the FSM SHALL stay in ALL_RED.
REQ-016 A_GREEN SHALL hold while A is requested; registered Astop=1 SHALL go to A_AMBER and load the counter with AMBER_CYC-1.
REQ-017 A_AMBER SHALL decrement the counter and, at zero, go to CLR_AB and load the counter with CLEAR_CYC-1; the amber lamp SHALL be lit for exactly AMBER_CYC cycles.
REQ-018 CLR_AB SHALL decrement the counter and, at zero, go to B_GREEN if registered Bgo=1 and Bstop=0, otherwise to ALL_RED.
REQ-019 B_GREEN, B_AMBER and CLR_BA SHALL mirror REQ-016 to REQ-018 with A and B swapped.
REQ-020 Lamp outputs per state: A_GREEN gives a_green and b_red; A_AMBER gives a_amber and b_red; ALL_RED, CLR_AB and CLR_BA give a_red and b_red; the B states mirror this.
REQ-021 Exactly one lamp per approach SHALL be lit in every non-FAULT state.
REQ-022 A green request arriving during amber or clearance SHALL NOT shorten either interval.
REQ-023 Go requests SHALL be ignored in the amber and clearance states, apart from the exit test in REQ-018.
REQ-024 Registered Ago=1 together with Bgo=1, or go=1 together with stop=1 on the same approach, SHALL go to FAULT from any state.
REQ-025 A fault condition SHALL take priority over every other transition in the same cycle.
REQ-026 In FAULT, fault SHALL be 1; a_red and b_red SHALL toggle together every BLINK_CYC cycles, starting lit; amber and green lamps SHALL be 0.
REQ-027 FAULT SHALL be exited only by reset.
REQ-028 Go=0 with stop=0 on both approaches, as seen during the upstream INIT state, SHALL be legal and SHALL hold the current state.
REQ-029 The counter SHALL be NBITS wide, unsigned, and SHALL decrement to zero without wrapping.

Reset
REQ-030 While reset_n=0, the FSM SHALL be in ALL_RED, the counter SHALL be 0, and input registers SHALL be 0.
REQ-031 While reset_n=0, a_red and b_red SHALL be 1, and all other lamp outputs and fault SHALL be 0.
REQ-032 Reset asserted mid-amber, mid-clearance or in FAULT SHALL give the REQ-030/031 values immediately, without waiting for a clock.
REQ-033 After release, operation SHALL resume from ALL_RED on the first rising clk edge.

Structure
REQ-034 The state encodings and lamp-pattern constants SHALL live in the shared package signal_pkg.
REQ-035 The loadable down-counter with zero flag SHALL be the sub-module phase_cnt, reused for both the interval and blink timing.

Verification
REQ-036 Bench parameters SHALL be AMBER_CYC=4, CLEAR_CYC=2, BLINK_CYC=3.
REQ-037 Scenario: reset, then Ago=1, Bstop=1 -> a_green=1 and b_red=1 two edges after the input change.
REQ-038 Scenario: from A_GREEN, Astop=1, Ago=0, Bgo=1 -> a_amber for 4 cycles, then all-red for 2 cycles, then b_green=1.
REQ-039 Scenario: from A_GREEN, Astop=1 with Bgo=0 -> amber 4 cycles, clearance 2 cycles, then ALL_RED held until Bgo=1.
REQ-040 Scenario: Ago=1 and Bgo=1 in the same cycle -> fault=1; red lamps toggle every 3 cycles; state is held until reset.
REQ-041 Scenario: reset_n pulled low between clk edges during A_AMBER -> a_red=b_red=1 and all others 0 with no clk edge.
REQ-042 Scenario: Bgo pulsed for 1 cycle during A_AMBER -> amber still lasts exactly 4 cycles and clearance exactly 2 cycles.
